lfsr_rng_hex: RTL

- Parametrised Fibonacci LFSR pseudo-random generator with free-run, single-step and seed-load modes.
- Includes zero-lockup recovery, period-completion detection and a registered 7-segment hex display of the full state.
- Sits between board switches/keys and the HEX bank; successor to the fixed 8-bit generator with 2-digit display.

---
 rtl/lfsr_rng_hex.sv | 120 ++++++++++++
 1 files changed

// File: rtl/lfsr_rng_hex.sv
// Fibonacci LFSR generator with free-run/single-step/seed-load, lockup recovery, period detect and hex display.
// Latency: one clock from input to randnum/hex/flags; hex is encoded from the next state so it matches randnum.
// Backpressure: none; every input is sampled each cycle and every output is a plain register.
module lfsr_rng_hex #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'h1D,
  parameter logic [WIDTH-1:0] SEED  = 8'h0A,
  parameter int               NDIG  = WIDTH / 4
) (
  input  logic                  clk,
  input  logic                  clrn,
  input  logic                  en,
  input  logic                  step,
  input  logic                  ld,
  input  logic [WIDTH-1:0]      ld_data,
  output logic [WIDTH-1:0]      randnum,
  output logic                  rnd_vld,
  output logic                  period_done,
  output logic [WIDTH-1:0]      step_cnt,
  output logic [7*NDIG-1:0]     hex
);

  logic [WIDTH-1:0] seed_q;
  logic [WIDTH-1:0] shift_nxt;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] state_nxt;
  logic [WIDTH-1:0] seed_nxt;
  logic [WIDTH-1:0] cnt_nxt;
  logic             vld_nxt;
  logic             pd_nxt;
  logic             fb;

  // Active-low gfedcba glyph for one nibble.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    s = 7'h7F;
    case (d)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Encodes every nibble of a state word into its digit slot.
  function automatic logic [7*NDIG-1:0] hex_enc(input logic [WIDTH-1:0] v);
    logic [7*NDIG-1:0] h;
    h = '0;
    for (int k = 0; k < NDIG; k++) begin
      h[7*k +: 7] = seg7(v[4*k +: 4]);
    end
    return h;
  endfunction

  // Next-state selection: load beats advance; a zero state is replaced by SEED so the LFSR never sticks.
  always_comb begin
    fb        = ^(randnum & TAPS);
    shift_nxt = {fb, randnum[WIDTH-1:1]};
    load_val  = (ld_data == '0) ? SEED : ld_data;
    state_nxt = randnum;
    seed_nxt  = seed_q;
    cnt_nxt   = step_cnt;
    vld_nxt   = 1'b0;
    pd_nxt    = 1'b0;
    if (ld) begin
      state_nxt = load_val;
      seed_nxt  = load_val;
      cnt_nxt   = '0;
      vld_nxt   = 1'b1;
    end else if (en || step) begin
      vld_nxt = 1'b1;
      if (randnum == '0) begin
        state_nxt = SEED;
        cnt_nxt   = step_cnt + 1'b1;
      end else if (shift_nxt == seed_q) begin
        // Back at the seed: one full period; the counter restarts instead of wrapping.
        state_nxt = shift_nxt;
        pd_nxt    = 1'b1;
        cnt_nxt   = '0;
      end else begin
        state_nxt = shift_nxt;
        cnt_nxt   = step_cnt + 1'b1;
      end
    end
  end

  // State, flags and display registers; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      randnum     <= SEED;
      seed_q      <= SEED;
      step_cnt    <= '0;
      rnd_vld     <= 1'b0;
      period_done <= 1'b0;
      hex         <= hex_enc(SEED);
    end else begin
      randnum     <= state_nxt;
      seed_q      <= seed_nxt;
      step_cnt    <= cnt_nxt;
      rnd_vld     <= vld_nxt;
      period_done <= pd_nxt;
      hex         <= hex_enc(state_nxt);
    end
  end

endmodule
